// File: rtl/mult_rr_arbiter_if.sv
// Request/response bundle between N_REQ multiply requesters and the shared
// multiplier arbiter. master = requester/consumer side, slave = arbiter side.
interface mult_rr_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_a;
  logic [4*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic [7:0]         rsp_product;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_ready;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id, busy
  );
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one signed 4x4 multiplier among N_REQ requesters;
// IDLE grants, CALC multiplies, RESP holds the tagged product until accepted.
module mult_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input logic              clk,
  input logic              rst_n,
  mult_rr_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Shared multiplier: sign-extend both operands, the low 8 bits are exact.
  function automatic logic [7:0] mul4s(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] a_ext;
    logic [7:0] b_ext;
    a_ext = {{4{a[3]}}, a};
    b_ext = {{4{b[3]}}, b};
    return a_ext * b_ext;
  endfunction

  state_t           state_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [3:0]       op_a_r;
  logic [3:0]       op_b_r;
  logic [ID_W-1:0]  op_id_r;
  logic [7:0]       result_r;
  logic [ID_W-1:0]  rsp_id_r;
  logic             rsp_valid_r;
  logic             busy_r;

  logic [N_REQ-1:0] grant_s;
  logic [ID_W-1:0]  grant_id_s;
  logic             found_s;
  logic [3:0]       sel_a_s;
  logic [3:0]       sel_b_s;
  logic             accept_s;
  logic [7:0]       prod_s;
  int               scan_idx_s;

  // Round-robin scan starting at rr_ptr, wrapping explicitly for any N_REQ.
  always_comb begin
    grant_s    = '0;
    grant_id_s = '0;
    found_s    = 1'b0;
    sel_a_s    = 4'd0;
    sel_b_s    = 4'd0;
    scan_idx_s = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx_s = int'(rr_ptr_r) + k;
      if (scan_idx_s >= N_REQ) begin
        scan_idx_s = scan_idx_s - N_REQ;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!found_s && bus.req_valid[scan_idx_s]) begin
        found_s             = 1'b1;
        grant_s[scan_idx_s] = 1'b1;
        grant_id_s          = ID_W'(scan_idx_s);
        sel_a_s             = bus.req_a[4*scan_idx_s +: 4];
        sel_b_s             = bus.req_b[4*scan_idx_s +: 4];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant strobe only in IDLE and never while reset is being applied.
  always_comb begin
    if (rst_n && (state_r == ST_IDLE)) begin
      bus.req_ready = grant_s;
      accept_s      = found_s;
    end else begin
      bus.req_ready = '0;
      accept_s      = 1'b0;
    end
  end

  assign prod_s = mul4s(op_a_r, op_b_r);

  // Operation sequencer and all registered state/outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      op_a_r      <= 4'd0;
      op_b_r      <= 4'd0;
      op_id_r     <= '0;
      result_r    <= 8'd0;
      rsp_id_r    <= '0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            op_id_r <= grant_id_s;
            busy_r  <= 1'b1;
            state_r <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          result_r    <= prod_s;
          rsp_id_r    <= op_id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            if (op_id_r == ID_W'(N_REQ - 1)) begin
              rr_ptr_r <= '0;
            end else begin
              rr_ptr_r <= op_id_r + ID_W'(1);
            end
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_product = result_r;
  assign bus.rsp_id      = rsp_id_r;
  assign bus.busy        = busy_r;
endmodule
